// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_STARVE_LIMIT    = 4;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// One-bit-wide synchronous FIFO recording which side owns each granted,
// not-yet-answered memory request.
module mem_port_arbiter_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic             i_data,
  input  logic             i_pop,
  output logic             o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and LSU,
// returning in-order responses to whichever side issued each request.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i,
  output logic                    protocol_err_o
);

  // Handshake: a request transfers in the cycle where req and gnt are both
  // high; its single response arrives on a later cycle as an rvalid pulse,
  // and responses come back strictly in request order.

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_protocol_err;
  logic                w_full;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_instr_win;
  logic                w_data_win;
  logic                w_push;
  logic                w_pop;
  logic                w_head_bit;
  mem_owner_t          w_head;
  mem_owner_t          w_push_owner;

  // Data normally wins; a starved fetch side takes the port back.
  assign mem_req_o    = (instr_req_i | data_req_i) & ~w_full;
  assign w_instr_win  = mem_req_o & instr_req_i &
                        (~data_req_i | (r_starve_cnt == STARVE_MAX));
  assign w_data_win   = mem_req_o & data_req_i & ~w_instr_win;
  assign instr_gnt_o  = w_instr_win & mem_gnt_i;
  assign data_gnt_o   = w_data_win & mem_gnt_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (w_instr_win) begin
      mem_addr_o = instr_addr_i;
      mem_be_o   = '1;
    end else if (w_data_win) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign w_push       = mem_req_o & mem_gnt_i;
  assign w_push_owner = w_data_win ? OWNER_DATA : OWNER_INSTR;
  assign w_pop        = mem_rvalid_i & ~w_fifo_empty;
  assign w_head       = mem_owner_t'(w_head_bit);

  mem_port_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (w_push_owner),
    .i_pop   (w_pop),
    .o_data  (w_head_bit),
    .o_full  (w_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign instr_rvalid_o = w_pop & (w_head == OWNER_INSTR);
  assign data_rvalid_o  = w_pop & (w_head == OWNER_DATA);
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign protocol_err_o = r_protocol_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= '0;
    end else if (!instr_req_i || instr_gnt_o) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
    end
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_protocol_err <= 1'b0;
    else if (mem_rvalid_i && (w_count == '0)) r_protocol_err <= 1'b1;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified req/gnt/rvalid memory port between the core's instruction-fetch and data (LSU) interfaces. It sits between the core and a single memory model in system benches, so the trace unit sees realistic fetch stalls caused by data traffic. Responses are routed back in order by tracking the owner of every outstanding granted request.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, granted-but-unanswered requests allowed (>=1)
STARVE_LIMIT, 4, consecutive lost arbitration cycles before instruction side is forced to win (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_WIDTH  fetch address
instr_gnt_o  out  1  fetch granted
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  DATA_WIDTH  fetch response data
data_req_i  in  1  data request
data_addr_i  in  ADDR_WIDTH  data address
data_we_i  in  1  write enable
data_be_i  in  DATA_WIDTH/8  byte enables
data_wdata_i  in  DATA_WIDTH  write data
data_gnt_o  out  1  data granted
data_rvalid_o  out  1  data response valid
data_rdata_o  out  DATA_WIDTH  data response data
data_err_o  out  1  data response error
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_WIDTH  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory response data
mem_err_i  in  1  memory response error
protocol_err_o  out  1  sticky: rvalid received with no outstanding request

Behaviour:
- Single clock clk_i; asynchronous active-low reset rst_ni clears outstanding count, owner FIFO, starvation counter, and protocol_err_o to 0.
- Request path is combinational, zero latency: winner chosen in the same cycle; mem_req_o = (instr_req_i | data_req_i) & ~full.
- full = (outstanding == MAX_OUTSTANDING). A pop in the same cycle does not unblock; requests stay blocked that cycle.
- Winner selection:
  - data wins when both request;
  - instruction wins if starve_cnt == STARVE_LIMIT;
  - a sole requester always wins.
- Mux: mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o follow the winner. When instruction wins, mem_we_o = 0 and mem_be_o = all ones. With no winner, all mem_* outputs are 0.
- Grant: winner_gnt_o = mem_req_o & mem_gnt_i. The loser's gnt_o is 0.
- starve_cnt (saturating at STARVE_LIMIT):
  - increments on a cycle where instr_req_i = 1 and instruction is not granted;
  - clears on instruction grant or instr_req_i = 0.
- Owner FIFO, depth MAX_OUTSTANDING, 1 bit per entry: pushes the winner's owner on each grant; pops on mem_rvalid_i.
- outstanding counter, width $clog2(MAX_OUTSTANDING+1): +1 on grant, -1 on valid pop, both in the same cycle leaves it unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Response routing: on mem_rvalid_i with non-empty FIFO, the head owner's rvalid_o = 1 for that cycle. instr_rdata_o and data_rdata_o both always equal mem_rdata_i. data_err_o = mem_rvalid_i & mem_err_i & head==DATA. mem_err_i on an instruction response is dropped.
- Empty-FIFO rvalid: mem_rvalid_i while outstanding == 0 is ignored (no rvalid_o, no pop) and sets protocol_err_o, which stays set until reset. This holds even if a grant occurs in that same cycle, because memory returns rvalid at least 1 cycle after gnt.
- Reset mid-operation discards all outstanding ownership; any later stale rvalid sets protocol_err_o.
- Reset values of outputs: every gnt/rvalid/err output is 0; mem_* outputs follow their combinational equations, so they are 0 while inputs are idle.

Decomposition:
- ryuki_datatypes gains typedef enum logic {OWNER_INSTR, OWNER_DATA} mem_owner_t.
- Default depth/limit constants go into ryuki_defines alongside ADDR_WIDTH/DATA_WIDTH.
- One sub-module, owner_fifo: a parameterised 1-bit-wide synchronous FIFO with push/pop/full/empty/count and async active-low reset.

Test Plan:
- Instr-only fetch 0x20: mem_gnt_i=1 in the same cycle -> instr_gnt_o=1, mem_we_o=0, mem_be_o=4'hF; rvalid one cycle later with rdata 0xDEADBEEF -> instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF.
- Both request every cycle, mem_gnt_i=1: data granted 4 cycles, instruction granted on cycle 5 (STARVE_LIMIT=4), pattern repeats.
- Four grants with no responses: 5th request cycle has mem_req_o=0 and no gnt. Responses then return in order D,I,D,I, each routed to the matching side.
- Data read answered with mem_err_i=1 -> data_err_o=1 and data_rvalid_o=1. Instruction response with mem_err_i=1 -> instr_rvalid_o=1, data_err_o=0.
- mem_rvalid_i pulsed right after reset -> protocol_err_o=1 and held; no rvalid_o asserted.
- rst_ni pulsed low with 2 outstanding -> outputs 0 and outstanding 0 asynchronously; next request is granted immediately.
